// File: rtl/dmem_store_buffer_pkg.sv
// Shared constants for the data-memory store buffer.
// Holds the default data/address width, the default buffer depth and the
// drain FSM state encoding used by dmem_store_buffer.
package dmem_store_buffer_pkg;

    localparam int SB_XLEN  = 32;
    localparam int SB_DEPTH = 4;

    typedef logic [0:0] sb_state_t;

    // Drain FSM encoding: IDLE = 0, ISSUE = 1
    localparam sb_state_t SB_IDLE  = 1'b0;
    localparam sb_state_t SB_ISSUE = 1'b1;

endpackage

// File: rtl/dmem_store_buffer_fifo.sv
// sb_fifo: in-order storage for pending stores {addr, wdata, mask}.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   push, push_*        - write one entry at the tail (caller guarantees not full)
//   pop                 - drop the head entry (caller guarantees not empty)
//   head_*              - payload of the oldest entry
//   ent_word, ent_valid - word address and occupancy of every slot, for hazard checks
//   count               - number of occupied entries
// Payload storage is deliberately left out of reset; only pointers and count clear.
module sb_fifo
    import dmem_store_buffer_pkg::*;
#(
    parameter int XLEN  = SB_XLEN,
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [XLEN-1:0]                push_addr,
    input  logic [XLEN-1:0]                push_wdata,
    input  logic [XLEN-1:0]                push_mask,
    input  logic                           pop,
    output logic [XLEN-1:0]                head_addr,
    output logic [XLEN-1:0]                head_wdata,
    output logic [XLEN-1:0]                head_mask,
    output logic [DEPTH-1:0][XLEN-3:0]     ent_word,
    output logic [DEPTH-1:0]               ent_valid,
    output logic [$clog2(DEPTH):0]         count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [DEPTH-1:0][XLEN-1:0] addr_mem_r;
    logic [DEPTH-1:0][XLEN-1:0] wdata_mem_r;
    logic [DEPTH-1:0][XLEN-1:0] mask_mem_r;
    logic [AW-1:0]              wr_ptr_r;
    logic [AW-1:0]              rd_ptr_r;
    logic [CW-1:0]              count_r;
    logic [AW-1:0]              offs_s;

    // Payload write at the tail slot (no reset on storage)
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_r[wr_ptr_r]  <= push_addr;
            wdata_mem_r[wr_ptr_r] <= push_wdata;
            mask_mem_r[wr_ptr_r]  <= push_mask;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Slot i is occupied when its distance from the head is below count
    always_comb begin
        ent_valid = {DEPTH{1'b0}};
        ent_word  = '{default: {(XLEN-2){1'b0}}};
        offs_s    = {AW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            offs_s       = AW'(i) - rd_ptr_r;
            ent_valid[i] = ({1'b0, offs_s} < count_r);
            ent_word[i]  = addr_mem_r[i][XLEN-1:2];
        end
    end

    assign head_addr  = addr_mem_r[rd_ptr_r];
    assign head_wdata = wdata_mem_r[rd_ptr_r];
    assign head_mask  = mask_mem_r[rd_ptr_r];
    assign count      = count_r;

endmodule

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: in-order store buffer between the MEM stage and data memory.
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   st_valid/st_addr/st_wdata/st_mask, st_ready - store offer from MEM and accept
//   ld_valid/ld_addr, ld_hazard    - word-granular RAW check for the load in MEM
//   fence_req, fence_done          - drain request and drained indication
//   mem_req/mem_addr/mem_wdata/mem_wmask, mem_ack - data-memory write port
//   count                          - occupied entries
// A two-state drain FSM issues the head entry whenever the buffer is non-empty.
module dmem_store_buffer
    import dmem_store_buffer_pkg::*;
#(
    parameter int XLEN  = SB_XLEN,
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   st_valid,
    input  logic [XLEN-1:0]        st_addr,
    input  logic [XLEN-1:0]        st_wdata,
    input  logic [XLEN-1:0]        st_mask,
    output logic                   st_ready,
    input  logic [XLEN-1:0]        ld_addr,
    input  logic                   ld_valid,
    output logic                   ld_hazard,
    input  logic                   fence_req,
    output logic                   fence_done,
    output logic                   mem_req,
    output logic [XLEN-1:0]        mem_addr,
    output logic [XLEN-1:0]        mem_wdata,
    output logic [XLEN-1:0]        mem_wmask,
    input  logic                   mem_ack,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;

    sb_state_t                  state_r;
    sb_state_t                  state_nxt_s;
    logic                       push_s;
    logic                       pop_s;
    logic [CW-1:0]              count_s;
    logic [CW-1:0]              post_count_s;
    logic [XLEN-1:0]            head_addr_s;
    logic [XLEN-1:0]            head_wdata_s;
    logic [XLEN-1:0]            head_mask_s;
    logic [DEPTH-1:0][XLEN-3:0] ent_word_s;
    logic [DEPTH-1:0]           ent_valid_s;
    logic                       hit_s;
    logic                       unused_ld_lsb_s;

    // Byte offset within the word is irrelevant to the hazard check
    assign unused_ld_lsb_s = ^ld_addr[1:0];

    assign st_ready = (count_s < CW'(DEPTH)) && !fence_req;
    assign push_s   = st_valid && st_ready;
    assign pop_s    = (state_r == SB_ISSUE) && mem_ack;
    assign count    = count_s;

    sb_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_addr  (st_addr),
        .push_wdata (st_wdata),
        .push_mask  (st_mask),
        .pop        (pop_s),
        .head_addr  (head_addr_s),
        .head_wdata (head_wdata_s),
        .head_mask  (head_mask_s),
        .ent_word   (ent_word_s),
        .ent_valid  (ent_valid_s),
        .count      (count_s)
    );

    // Drain FSM next state; ISSUE continues while the post-update count is non-zero
    always_comb begin
        state_nxt_s  = state_r;
        post_count_s = count_s + CW'(push_s) - CW'(pop_s);
        case (state_r)
            SB_IDLE: begin
                if (count_s != {CW{1'b0}}) begin
                    state_nxt_s = SB_ISSUE;
                end else begin
                    state_nxt_s = SB_IDLE;
                end
            end
            SB_ISSUE: begin
                if (pop_s) begin
                    if (post_count_s != {CW{1'b0}}) begin
                        state_nxt_s = SB_ISSUE;
                    end else begin
                        state_nxt_s = SB_IDLE;
                    end
                end else begin
                    state_nxt_s = SB_ISSUE;
                end
            end
            default: state_nxt_s = SB_IDLE;
        endcase
    end

    // Drain FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= SB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Write port presents the head only while issuing, zeros otherwise
    always_comb begin
        mem_req = (state_r == SB_ISSUE);
        if (state_r == SB_ISSUE) begin
            mem_addr  = head_addr_s;
            mem_wdata = head_wdata_s;
            mem_wmask = head_mask_s;
        end else begin
            mem_addr  = {XLEN{1'b0}};
            mem_wdata = {XLEN{1'b0}};
            mem_wmask = {XLEN{1'b0}};
        end
    end

    // Any occupied entry (head included) in the load's word raises a hazard;
    // the store being offered this cycle is not yet an entry and is not compared
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_s = hit_s | (ent_valid_s[i] && (ent_word_s[i] == ld_addr[XLEN-1:2]));
        end
        ld_hazard = ld_valid && hit_s;
    end

    assign fence_done = fence_req && (count_s == {CW{1'b0}}) && (state_r == SB_IDLE) && !rst;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed self-checking bench for dmem_store_buffer (XLEN=32, DEPTH=4).
module tb_dmem_store_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            st_valid = 1'b0;
    logic [XLEN-1:0] st_addr = 32'h0;
    logic [XLEN-1:0] st_wdata = 32'h0;
    logic [XLEN-1:0] st_mask = 32'h0;
    logic            st_ready;
    logic [XLEN-1:0] ld_addr = 32'h0;
    logic            ld_valid = 1'b0;
    logic            ld_hazard;
    logic            fence_req = 1'b0;
    logic            fence_done;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_wmask;
    logic            mem_ack = 1'b0;
    logic [CW-1:0]   count;

    int n_cmp = 0;
    int n_err = 0;

    dmem_store_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_wdata   (st_wdata),
        .st_mask    (st_mask),
        .st_ready   (st_ready),
        .ld_addr    (ld_addr),
        .ld_valid   (ld_valid),
        .ld_hazard  (ld_hazard),
        .fence_req  (fence_req),
        .fence_done (fence_done),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_ack    (mem_ack),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_fence_done", 32'(fence_done), 32'd0);
        check("rst_ld_hazard", 32'(ld_hazard), 32'd0);
        rst = 1'b0;
        settle();
        check("rst_st_ready", 32'(st_ready), 32'd1);

        // Single sw, ack two cycles after mem_req rises
        st_valid = 1'b1; st_addr = 32'h100; st_wdata = 32'hDEADBEEF; st_mask = 32'hFFFFFFFF;
        settle();
        check("t1_ready", 32'(st_ready), 32'd1);
        check("t1_req_pre", 32'(mem_req), 32'd0);
        tick();
        st_valid = 1'b0;
        settle();
        check("t1_count1", 32'(count), 32'd1);
        check("t1_req_push_cyc", 32'(mem_req), 32'd0);
        tick(); settle();
        check("t1_req_c1", 32'(mem_req), 32'd1);
        check("t1_addr", mem_addr, 32'h100);
        check("t1_wdata", mem_wdata, 32'hDEADBEEF);
        check("t1_wmask", mem_wmask, 32'hFFFFFFFF);
        tick(); settle();
        check("t1_req_c2", 32'(mem_req), 32'd1);
        check("t1_addr_hold", mem_addr, 32'h100);
        tick();
        mem_ack = 1'b1;
        settle();
        check("t1_req_c3", 32'(mem_req), 32'd1);
        tick();
        mem_ack = 1'b0;
        settle();
        check("t1_req_done", 32'(mem_req), 32'd0);
        check("t1_count0", 32'(count), 32'd0);
        check("t1_addr_idle", mem_addr, 32'h0);
        check("t1_wdata_idle", mem_wdata, 32'h0);

        // Five back-to-back stores with no ack: fifth stalls
        for (int i = 0; i < 5; i++) begin
            st_valid = 1'b1; st_addr = 32'h10 + 32'(4 * i); st_wdata = 32'(i); st_mask = 32'hFFFFFFFF;
            settle();
            check("t2_ready", 32'(st_ready), (i < 4) ? 32'd1 : 32'd0);
            tick();
        end
        st_valid = 1'b0;
        settle();
        check("t2_count_full", 32'(count), 32'd4);
        check("t2_ready_full", 32'(st_ready), 32'd0);
        check("t2_head", mem_addr, 32'h10);

        // Full with ack and st_valid together: pop only
        mem_ack = 1'b1; st_valid = 1'b1; st_addr = 32'h30; st_wdata = 32'h99;
        settle();
        check("t3_ready_full", 32'(st_ready), 32'd0);
        tick();
        mem_ack = 1'b0; st_valid = 1'b0;
        settle();
        check("t3_count3", 32'(count), 32'd3);
        check("t3_ready_after", 32'(st_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("t3_head_addr", mem_addr, 32'h14 + 32'(4 * k));
            check("t3_head_data", mem_wdata, 32'(k + 1));
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            settle();
        end
        check("t3_drained", 32'(count), 32'd0);
        check("t3_req_off", 32'(mem_req), 32'd0);

        // Load hazard on word address only
        st_valid = 1'b1; st_addr = 32'h203; st_wdata = 32'hAB000000; st_mask = 32'hFF000000;
        ld_valid = 1'b1; ld_addr = 32'h200;
        settle();
        check("t4_no_same_cycle", 32'(ld_hazard), 32'd0);
        tick();
        st_valid = 1'b0;
        settle();
        check("t4_hit_200", 32'(ld_hazard), 32'd1);
        ld_addr = 32'h204; settle();
        check("t4_miss_204", 32'(ld_hazard), 32'd0);
        ld_addr = 32'h1FF; settle();
        check("t4_miss_1ff", 32'(ld_hazard), 32'd0);
        ld_addr = 32'h200; ld_valid = 1'b0; settle();
        check("t4_no_ld_valid", 32'(ld_hazard), 32'd0);
        ld_valid = 1'b1;
        tick(); settle();
        check("t4_issue_req", 32'(mem_req), 32'd1);
        check("t4_issue_mask", mem_wmask, 32'hFF000000);
        check("t4_hit_head", 32'(ld_hazard), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; ld_valid = 1'b0;
        settle();
        check("t4_drained", 32'(count), 32'd0);

        // mem_ack outside ISSUE is ignored
        st_valid = 1'b1; st_addr = 32'h500; st_wdata = 32'h5; st_mask = 32'h0000FFFF; mem_ack = 1'b1;
        tick();
        st_valid = 1'b0;
        settle();
        check("t5_count_idle_ack", 32'(count), 32'd1);
        check("t5_req_idle", 32'(mem_req), 32'd0);
        tick(); settle();
        check("t5_count_enter", 32'(count), 32'd1);
        check("t5_req_issue", 32'(mem_req), 32'd1);
        tick();
        mem_ack = 1'b0;
        settle();
        check("t5_count_pop", 32'(count), 32'd0);
        check("t5_req_off", 32'(mem_req), 32'd0);

        // Fence with two pending entries
        st_valid = 1'b1; st_addr = 32'h400; st_wdata = 32'h1; st_mask = 32'hFFFFFFFF;
        tick();
        st_addr = 32'h404; st_wdata = 32'h2;
        tick();
        st_valid = 1'b0; fence_req = 1'b1;
        settle();
        check("t6_ready_fence", 32'(st_ready), 32'd0);
        check("t6_done_pend", 32'(fence_done), 32'd0);
        check("t6_count2", 32'(count), 32'd2);
        mem_ack = 1'b1;
        tick(); settle();
        check("t6_count1", 32'(count), 32'd1);
        check("t6_done_one", 32'(fence_done), 32'd0);
        tick();
        mem_ack = 1'b0;
        settle();
        check("t6_count0", 32'(count), 32'd0);
        check("t6_done", 32'(fence_done), 32'd1);
        fence_req = 1'b0;
        settle();
        check("t6_done_drop", 32'(fence_done), 32'd0);

        // Asynchronous reset mid-transaction with three entries
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1; st_addr = 32'h600 + 32'(4 * i); st_wdata = 32'(i); st_mask = 32'hFFFFFFFF;
            tick();
        end
        st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h604;
        settle();
        check("t7_req_before", 32'(mem_req), 32'd1);
        check("t7_count3", 32'(count), 32'd3);
        check("t7_hazard_before", 32'(ld_hazard), 32'd1);
        #1;
        rst = 1'b1; fence_req = 1'b1;
        #1;
        check("t7_req_async", 32'(mem_req), 32'd0);
        check("t7_count_async", 32'(count), 32'd0);
        check("t7_hazard_async", 32'(ld_hazard), 32'd0);
        check("t7_done_async", 32'(fence_done), 32'd0);
        tick();
        rst = 1'b0; fence_req = 1'b0; ld_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t7_req_quiet", 32'(mem_req), 32'd0);
            check("t7_count_quiet", 32'(count), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_store_buffer.md
DMEM_STORE_BUFFER -- requirements
Module: dmem_store_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address/mask width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of store entries (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port st_valid, input, 1 bit: a store is offered from the MEM stage.
REQ-006 SHALL have port st_addr, input, XLEN bits: store byte address.
REQ-007 SHALL have port st_wdata, input, XLEN bits: lane-aligned store data (already shifted).
REQ-008 SHALL have port st_mask, input, XLEN bits: bit-level write mask (FFFFFFFF, 0000FFFF<<k, 000000FF<<k).
REQ-009 SHALL have port st_ready, output, 1 bit: the buffer accepts the store this cycle.
REQ-010 SHALL have port ld_addr, input, XLEN bits: address of the load currently in MEM.
REQ-011 SHALL have port ld_valid, input, 1 bit: ld_addr is meaningful.
REQ-012 SHALL have port ld_hazard, output, 1 bit: a pending store targets the load's word.
REQ-013 SHALL have port fence_req, input, 1 bit: a drain is requested (fence/ecall/CSR).
REQ-014 SHALL have port fence_done, output, 1 bit: the buffer is drained and the fence may retire.
REQ-015 SHALL have ports mem_req (output, 1), mem_addr (output, XLEN), mem_wdata (output, XLEN), mem_wmask (output, XLEN) and mem_ack (input, 1): the data-memory write port.
REQ-016 SHALL have port count, output, $clog2(DEPTH)+1 bits: number of occupied entries.

Function
REQ-017 SHALL implement an in-order FIFO of {addr, wdata, mask} entries, with write pointer, read pointer and count registers.
REQ-018 SHALL drive st_ready = (count < DEPTH) && !fence_req; a push occurs on st_valid && st_ready.
REQ-019 SHALL not accept a push when full, even if a pop occurs in the same cycle.
REQ-020 SHALL implement a drain FSM with two states: IDLE and ISSUE.
REQ-021 SHALL move IDLE->ISSUE at the edge where count != 0 (count as registered, before the current push).
REQ-022 SHALL, in ISSUE, drive mem_req=1 and mem_addr/mem_wdata/mem_wmask from the head entry, held stable until mem_ack.
REQ-023 SHALL, on mem_ack in ISSUE, pop the head entry; the FSM stays in ISSUE if the post-update count != 0, otherwise it returns to IDLE.
REQ-024 SHALL ignore mem_ack outside ISSUE.
REQ-025 SHALL drive mem_req=0 and all mem_* data outputs to 0 in IDLE.
REQ-026 SHALL give a push-to-mem_req latency of 1 cycle minimum when IDLE and empty.
REQ-027 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-028 SHALL let the pointers wrap modulo DEPTH.
REQ-029 SHALL assert ld_hazard combinationally when ld_valid is high and any occupied entry satisfies addr[XLEN-1:2]==ld_addr[XLEN-1:2] (including the head being issued).
REQ-030 SHALL not compare the same-cycle incoming store against ld_addr.
REQ-031 SHALL drive fence_done = fence_req && (count==0) && (state==IDLE), combinationally.

Reset
REQ-032 SHALL, on rst high, asynchronously force state=IDLE, pointers=0, count=0, mem_req=0, ld_hazard=0 and fence_done=0.
REQ-033 SHALL, on rst mid-transaction, drop mem_req immediately and discard all pending entries; entry payload storage is not reset.

Structure
REQ-034 SHALL place the FSM state encoding (IDLE=0, ISSUE=1) and the DEPTH default in the shared CPU package/defines, alongside XLEN.
REQ-035 SHALL use sub-module sb_fifo for pointer/count/storage, with the address compare and FSM in the top.

Verification
REQ-036 SHALL cover: single sw addr=0x100, data=0xDEADBEEF, mask=FFFFFFFF, mem_ack 2 cycles after mem_req -> mem_req rises 1 cycle after push, held 3 cycles, count 1->0.
REQ-037 SHALL cover: 5 back-to-back stores with mem_ack held low -> st_ready falls after the 4th store, the 5th is stalled, count=4.
REQ-038 SHALL cover: full buffer with mem_ack and st_valid in the same cycle -> pop only, count=3, st_ready=1 on the next cycle.
REQ-039 SHALL cover: pending sb to 0x203, then load from 0x200 -> ld_hazard=1; load from 0x204 -> ld_hazard=0.
REQ-040 SHALL cover: fence_req with 2 entries pending -> st_ready=0, fence_done=1 only in the cycle after the 2nd mem_ack.
REQ-041 SHALL cover: rst pulsed while mem_req=1 with 3 entries -> mem_req=0 asynchronously, count=0, and no further mem_req.
